mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between an instruction-fetch port and a data port.
// Data wins by default; a starvation counter forces a fetch grant after repeated losses.
module mem_port_arbiter #(
    parameter int unsigned XLEN          = 32,
    parameter logic [2:0]  FETCH_RD_CTRL = 3'b010,
    parameter int unsigned STARVE_MAX    = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            if_req_valid,
    input  logic [XLEN-1:0] if_req_addr,
    output logic            if_req_ready,
    output logic            if_resp_valid,
    output logic [XLEN-1:0] if_resp_data,

    input  logic            d_req_valid,
    input  logic [2:0]      d_req_rd_ctrl,
    input  logic [1:0]      d_req_wr_ctrl,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic [XLEN-1:0] d_req_wdata,
    output logic            d_req_ready,
    output logic            d_resp_valid,
    output logic [XLEN-1:0] d_resp_data,

    output logic [2:0]      sram_rd_ctrl,
    output logic [1:0]      sram_wr_ctrl,
    output logic [XLEN-1:0] sram_addr,
    output logic [XLEN-1:0] sram_wdata,
    input  logic [XLEN-1:0] sram_rdata
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             r_d_wr;
    logic             r_d_nop;

    logic             w_fetch_forced;
    logic             w_if_grant;
    logic             w_d_grant;
    logic             w_d_wr;
    logic             w_d_nop;

    // Grants are masked while in reset so no request is accepted during it.
    assign w_fetch_forced = (r_starve_cnt == CNT_MAX);
    assign w_if_grant     = rst_n && if_req_valid && (!d_req_valid || w_fetch_forced);
    assign w_d_grant      = rst_n && d_req_valid && !w_if_grant;
    assign w_d_wr         = (d_req_wr_ctrl != 2'b00);
    assign w_d_nop        = (d_req_wr_ctrl == 2'b00) && (d_req_rd_ctrl == 3'b000);

    always_comb begin
        if (!if_req_valid || w_if_grant) begin
            w_starve_nxt = '0;
        end else if (w_d_grant && (r_starve_cnt != CNT_MAX)) begin
            w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_d_wr       <= 1'b0;
            r_d_nop      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            if (w_d_grant) begin
                r_d_wr  <= w_d_wr;
                r_d_nop <= w_d_nop;
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statements can leave a latch behind.
    always_comb begin
        w_state_nxt   = IDLE;
        if_req_ready  = w_if_grant;
        d_req_ready   = w_d_grant;
        if_resp_valid = 1'b0;
        if_resp_data  = '0;
        d_resp_valid  = 1'b0;
        d_resp_data   = '0;
        sram_rd_ctrl  = 3'b000;
        sram_wr_ctrl  = 2'b00;
        sram_addr     = '0;
        sram_wdata    = '0;

        if (w_if_grant) begin
            w_state_nxt  = RESP_IF;
            sram_rd_ctrl = FETCH_RD_CTRL;
            sram_addr    = if_req_addr;
        end else if (w_d_grant) begin
            w_state_nxt  = RESP_D;
            sram_rd_ctrl = w_d_wr ? 3'b000 : d_req_rd_ctrl;
            sram_wr_ctrl = d_req_wr_ctrl;
            sram_addr    = d_req_addr;
            sram_wdata   = d_req_wdata;
        end

        // A response still pending when reset arrives is dropped.
        if (rst_n) begin
            case (r_state)
                RESP_IF: begin
                    if_resp_valid = 1'b1;
                    if_resp_data  = sram_rdata;
                end
                RESP_D: begin
                    d_resp_valid = 1'b1;
                    if (!r_d_wr && !r_d_nop) begin
                        d_resp_data = sram_rdata;
                    end
                end
                default: begin
                    if_resp_valid = 1'b0;
                    d_resp_valid  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after the rising edge,
// outputs are checked 2 ns after it, with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_req_valid;
    logic [XLEN-1:0] if_req_addr;
    logic            if_req_ready;
    logic            if_resp_valid;
    logic [XLEN-1:0] if_resp_data;
    logic            d_req_valid;
    logic [2:0]      d_req_rd_ctrl;
    logic [1:0]      d_req_wr_ctrl;
    logic [XLEN-1:0] d_req_addr;
    logic [XLEN-1:0] d_req_wdata;
    logic            d_req_ready;
    logic            d_resp_valid;
    logic [XLEN-1:0] d_resp_data;
    logic [2:0]      sram_rd_ctrl;
    logic [1:0]      sram_wr_ctrl;
    logic [XLEN-1:0] sram_addr;
    logic [XLEN-1:0] sram_wdata;
    logic [XLEN-1:0] sram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_cnt_a  [6] = '{0, 1, 2, 3, 4, 0};
    int if_v_b     [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
    int exp_if_b   [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    int exp_cnt_b  [8] = '{0, 1, 2, 0, 1, 2, 3, 4};

    mem_port_arbiter #(
        .XLEN(XLEN),
        .FETCH_RD_CTRL(3'b010),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req_valid(if_req_valid),
        .if_req_addr(if_req_addr),
        .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid),
        .if_resp_data(if_resp_data),
        .d_req_valid(d_req_valid),
        .d_req_rd_ctrl(d_req_rd_ctrl),
        .d_req_wr_ctrl(d_req_wr_ctrl),
        .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata),
        .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid),
        .d_resp_data(d_resp_data),
        .sram_rd_ctrl(sram_rd_ctrl),
        .sram_wr_ctrl(sram_wr_ctrl),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        if_req_valid  = 1'b0;
        if_req_addr   = '0;
        d_req_valid   = 1'b0;
        d_req_rd_ctrl = 3'b000;
        d_req_wr_ctrl = 2'b00;
        d_req_addr    = '0;
        d_req_wdata   = '0;
        sram_rdata    = '0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [2:0] rd);
        d_req_valid   = 1'b1;
        d_req_rd_ctrl = rd;
        d_req_wr_ctrl = 2'b00;
        d_req_addr    = addr;
        d_req_wdata   = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_ready"},  32'(if_req_ready),  32'd0);
        check({tag, "_d_ready"},   32'(d_req_ready),   32'd0);
        check({tag, "_if_rvalid"}, 32'(if_resp_valid), 32'd0);
        check({tag, "_if_rdata"},  if_resp_data,       32'd0);
        check({tag, "_d_rvalid"},  32'(d_resp_valid),  32'd0);
        check({tag, "_d_rdata"},   d_resp_data,        32'd0);
        check({tag, "_sram_rd"},   32'(sram_rd_ctrl),  32'd0);
        check({tag, "_sram_wr"},   32'(sram_wr_ctrl),  32'd0);
        check({tag, "_sram_addr"}, sram_addr,          32'd0);
        check({tag, "_sram_wd"},   sram_wdata,         32'd0);
    endtask

    initial begin
        logic prev_if;

        // Reset with requests pending: nothing may be granted.
        rst_n = 1'b0;
        idle_inputs();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_1000;
        drive_load(32'h0000_2000, 3'b010);
        #1;
        settle();
        check_quiet("in_rst");
        tick();
        tick();
        rst_n = 1'b1;
        idle_inputs();
        settle();
        check_quiet("post_rst");
        check("post_rst_cnt", 32'(dut.r_starve_cnt), 32'd0);

        // Lone fetch.
        tick();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h8000_0000;
        settle();
        check("f1_if_ready", 32'(if_req_ready), 32'd1);
        check("f1_d_ready",  32'(d_req_ready),  32'd0);
        check("f1_sram_rd",  32'(sram_rd_ctrl), 32'd2);
        check("f1_sram_wr",  32'(sram_wr_ctrl), 32'd0);
        check("f1_addr",     sram_addr,         32'h8000_0000);
        check("f1_wdata",    sram_wdata,        32'd0);
        tick();
        idle_inputs();
        sram_rdata = 32'h0000_0013;
        settle();
        check("f1_rvalid",   32'(if_resp_valid), 32'd1);
        check("f1_rdata",    if_resp_data,       32'h0000_0013);
        check("f1_d_rvalid", 32'(d_resp_valid),  32'd0);
        check("f1_no_grant", 32'(sram_rd_ctrl),  32'd0);
        tick();
        sram_rdata = 32'h0000_0055;
        settle();
        check("f1_after_rvalid", 32'(if_resp_valid), 32'd0);
        check("f1_after_rdata",  if_resp_data,       32'd0);

        // Fetch and load together: data wins, counter goes to 1.
        tick();
        idle_inputs();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0040;
        drive_load(32'h0000_0100, 3'b010);
        settle();
        check("both_d_ready",  32'(d_req_ready),  32'd1);
        check("both_if_ready", 32'(if_req_ready), 32'd0);
        check("both_addr",     sram_addr,         32'h0000_0100);
        check("both_rd",       32'(sram_rd_ctrl), 32'd2);
        tick();
        idle_inputs();
        sram_rdata = 32'h0000_1234;
        settle();
        check("both_d_rvalid",  32'(d_resp_valid),  32'd1);
        check("both_d_rdata",   d_resp_data,        32'h0000_1234);
        check("both_if_rvalid", 32'(if_resp_valid), 32'd0);
        check("both_cnt",       32'(dut.r_starve_cnt), 32'd1);

        // Six cycles of contention: D,D,D,D,IF,D.
        prev_if = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            idle_inputs();
            if_req_valid = 1'b1;
            if_req_addr  = 32'h0000_0800 + 32'(k * 4);
            drive_load(32'h0000_0900 + 32'(k * 4), 3'b010);
            sram_rdata = 32'h0000_A000 + 32'(k);
            settle();
            check($sformatf("starve%0d_cnt", k), 32'(dut.r_starve_cnt), 32'(exp_cnt_a[k]));
            check($sformatf("starve%0d_if_ready", k), 32'(if_req_ready), (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("starve%0d_d_ready", k),  32'(d_req_ready),  (k == 4) ? 32'd0 : 32'd1);
            if (k > 0) begin
                check($sformatf("starve%0d_if_rvalid", k), 32'(if_resp_valid), prev_if ? 32'd1 : 32'd0);
                check($sformatf("starve%0d_d_rvalid", k),  32'(d_resp_valid),  prev_if ? 32'd0 : 32'd1);
                check($sformatf("starve%0d_rdata", k),
                      prev_if ? if_resp_data : d_resp_data, 32'h0000_A000 + 32'(k));
            end
            prev_if = (k == 4);
        end
        tick();
        idle_inputs();
        sram_rdata = 32'h0000_BBBB;
        settle();
        check("starve_tail_d_rvalid", 32'(d_resp_valid), 32'd1);
        check("starve_tail_d_rdata",  d_resp_data,       32'h0000_BBBB);

        // Store: read control suppressed, ack carries zero data.
        tick();
        idle_inputs();
        d_req_valid   = 1'b1;
        d_req_rd_ctrl = 3'b010;
        d_req_wr_ctrl = 2'b11;
        d_req_addr    = 32'h0000_0200;
        d_req_wdata   = 32'hDEAD_BEEF;
        settle();
        check("st_d_ready", 32'(d_req_ready),  32'd1);
        check("st_sram_wr", 32'(sram_wr_ctrl), 32'd3);
        check("st_sram_rd", 32'(sram_rd_ctrl), 32'd0);
        check("st_addr",    sram_addr,         32'h0000_0200);
        check("st_wdata",   sram_wdata,        32'hDEAD_BEEF);
        tick();
        idle_inputs();
        sram_rdata = 32'hFFFF_FFFF;
        settle();
        check("st_rvalid", 32'(d_resp_valid), 32'd1);
        check("st_rdata",  d_resp_data,       32'd0);

        // Data request with no read and no write is still acknowledged.
        tick();
        idle_inputs();
        drive_load(32'h0000_0300, 3'b000);
        settle();
        check("nop_d_ready", 32'(d_req_ready),  32'd1);
        check("nop_sram_rd", 32'(sram_rd_ctrl), 32'd0);
        check("nop_addr",    sram_addr,         32'h0000_0300);
        tick();
        idle_inputs();
        sram_rdata = 32'h0000_0077;
        settle();
        check("nop_rvalid", 32'(d_resp_valid), 32'd1);
        check("nop_rdata",  d_resp_data,       32'd0);

        // Back-to-back fetches, then a load granted alongside the last fetch response.
        for (int i = 0; i < 4; i++) begin
            tick();
            idle_inputs();
            if (i < 3) begin
                if_req_valid = 1'b1;
                if_req_addr  = 32'(i * 4);
            end else begin
                drive_load(32'h0000_0400, 3'b100);
            end
            sram_rdata = 32'h0000_0100 + 32'(i);
            settle();
            if (i < 3) begin
                check($sformatf("b2b%0d_if_ready", i), 32'(if_req_ready), 32'd1);
                check($sformatf("b2b%0d_addr", i),     sram_addr,         32'(i * 4));
            end else begin
                check("b2b3_d_ready",  32'(d_req_ready),  32'd1);
                check("b2b3_if_ready", 32'(if_req_ready), 32'd0);
                check("b2b3_sram_rd",  32'(sram_rd_ctrl), 32'd4);
            end
            if (i > 0) begin
                check($sformatf("b2b%0d_if_rvalid", i), 32'(if_resp_valid), 32'd1);
                check($sformatf("b2b%0d_if_rdata", i),  if_resp_data,       32'h0000_0100 + 32'(i));
            end
        end
        tick();
        idle_inputs();
        sram_rdata = 32'h0000_5A5A;
        settle();
        check("b2b_tail_d_rvalid",  32'(d_resp_valid),  32'd1);
        check("b2b_tail_d_rdata",   d_resp_data,        32'h0000_5A5A);
        check("b2b_tail_if_rvalid", 32'(if_resp_valid), 32'd0);

        // Counter clears on a cycle without a fetch request, then saturates to force fetch.
        for (int k = 0; k < 8; k++) begin
            tick();
            idle_inputs();
            if_req_valid = (if_v_b[k] != 0);
            if_req_addr  = 32'h0000_0C00;
            drive_load(32'h0000_0D00, 3'b010);
            settle();
            check($sformatf("clr%0d_cnt", k), 32'(dut.r_starve_cnt), 32'(exp_cnt_b[k]));
            check($sformatf("clr%0d_if_ready", k), 32'(if_req_ready), 32'(exp_if_b[k]));
            check($sformatf("clr%0d_d_ready", k),  32'(d_req_ready),  32'(1 - exp_if_b[k]));
        end
        tick();
        idle_inputs();
        settle();
        check("clr_tail_if_rvalid", 32'(if_resp_valid), 32'd1);

        // Reset right after a load grant discards the response.
        tick();
        idle_inputs();
        drive_load(32'h0000_0100, 3'b010);
        settle();
        check("rst_load_d_ready", 32'(d_req_ready), 32'd1);
        tick();
        rst_n = 1'b0;
        sram_rdata = 32'h0000_00AA;
        settle();
        check_quiet("rst_mid");
        tick();
        rst_n = 1'b1;
        idle_inputs();
        settle();
        check_quiet("rst_after");
        tick();
        settle();
        check_quiet("rst_after2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
